// File: rtl/fifo_drain.sv
// Read-side engine for a 4-entry FIFO: issues one pop at a time and buffers up to two
// captured words behind a valid/ready port. Define FIFO_DRAIN_CNT_EN to add drain_count.
module fifo_drain #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             drain_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             pop_fifo,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [15:0]      drain_count
`endif
);

    typedef enum logic {StIdle, StWait} state_e;

    localparam logic [2:0] LatInit = 3'(RD_LAT);

    state_e           state_q;
    logic [2:0]       lat_cnt_q;
    logic             pop_q;
    logic [WIDTH-1:0] mem_q [2];
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       occ_q, occ_d;
    logic             start;
    logic             capture;
    logic             xfer;

    // A pop is only launched with a free slot, so the capture can never overflow.
    assign start   = drain_en && !fifo_empty && (occ_q != 2'd2);
    assign capture = (state_q == StWait) && (lat_cnt_q == 3'd0);
    assign xfer    = (occ_q != 2'd0) && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            lat_cnt_q <= 3'd0;
            pop_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    pop_q <= 1'b0;
                    if (start) begin
                        state_q   <= StWait;
                        pop_q     <= 1'b1;
                        lat_cnt_q <= LatInit;
                    end
                end
                StWait: begin
                    pop_q <= 1'b0;
                    // lat_cnt reaches 0 in the cycle fifo_rd_data is valid.
                    if (lat_cnt_q == 3'd0) begin
                        state_q <= StIdle;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        head_d = head_q ^ xfer;
        tail_d = tail_q ^ capture;
        occ_d  = occ_q;
        unique case ({capture, xfer})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (capture) begin
                mem_q[tail_q] <= fifo_rd_data;
            end
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign pop_fifo  = pop_q;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = mem_q[head_q];

`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 16'd0;
        end else if (capture) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign drain_count = cnt_q;
`endif

endmodule
